pipe_addsub: RTL and testbench

PIPE_ADDSUB -- requirements
Module: pipe_addsub

---
 rtl/pipe_addsub.sv | 168 ++++++++++++++++
 tb/tb_pipe_addsub.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: SEG bits per stage with lookahead carries inside each
// stage, registered carry between stages, optional signed saturation at the output.
module pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  if (WIDTH % SEG != 0) begin : g_bad_seg
    $error("pipe_addsub: WIDTH must be a multiple of SEG");
  end
  if (WIDTH < 4) begin : g_bad_width
    $error("pipe_addsub: WIDTH must be at least 4");
  end

  // Handshake: a beat moves on a rising edge when valid and ready are both high.
  // The whole pipeline advances together whenever the output slot is empty or being
  // retired, so in_ready never depends on in_valid.
  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Carry i+1 is the OR of every generate term propagated up to bit i, plus cin
  // propagated through all lower bits -- each carry is a flat sum of products.
  function automatic logic [SEG:0] cla(input logic [SEG-1:0] g, input logic [SEG-1:0] p,
                                       input logic cin);
    logic t;
    cla    = '0;
    cla[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      t = cin;
      for (int m = 0; m <= i; m++) t = t & p[m];
      cla[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        cla[i+1] = cla[i+1] | t;
      end
    end
  endfunction

  // Intermediate stages: each consumes the low SEG bits of the remaining operands
  // and hands the unconsumed upper bits forward.
  for (genvar k = 0; k < LAST; k++) begin : g_st
    localparam int RIN  = WIDTH - k * SEG;
    localparam int RREM = RIN - SEG;
    localparam int DONE = (k + 1) * SEG;

    logic             v_i, c_i, sub_i, sat_i;
    logic [RIN-1:0]   a_i, b_i;
    logic             v_q, c_q, sub_q, sat_q;
    logic [RREM-1:0]  a_q, b_q;
    logic [DONE-1:0]  r_q, r_d;
    logic [SEG-1:0]   bs, sum;
    logic [SEG:0]     cy;

    if (k == 0) begin : g_src
      assign v_i   = in_valid;
      assign c_i   = sub;
      assign sub_i = sub;
      assign sat_i = sat;
      assign a_i   = a;
      assign b_i   = b;
      assign r_d   = sum;
    end else begin : g_src
      assign v_i   = g_st[k-1].v_q;
      assign c_i   = g_st[k-1].c_q;
      assign sub_i = g_st[k-1].sub_q;
      assign sat_i = g_st[k-1].sat_q;
      assign a_i   = g_st[k-1].a_q;
      assign b_i   = g_st[k-1].b_q;
      assign r_d   = {sum, g_st[k-1].r_q};
    end

    assign bs  = sub_i ? ~b_i[SEG-1:0] : b_i[SEG-1:0];
    assign cy  = cla(a_i[SEG-1:0] & bs, a_i[SEG-1:0] ^ bs, c_i);
    assign sum = a_i[SEG-1:0] ^ bs ^ cy[SEG-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sub_q <= 1'b0;
        sat_q <= 1'b0;
        a_q   <= '0;
        b_q   <= '0;
        r_q   <= '0;
      end else if (advance) begin
        v_q   <= v_i;
        c_q   <= cy[SEG];
        sub_q <= sub_i;
        sat_q <= sat_i;
        a_q   <= a_i[RIN-1:SEG];
        b_q   <= b_i[RIN-1:SEG];
        r_q   <= r_d;
      end
    end
  end

  // Final stage: top segment, overflow, saturation and flags feed the output register.
  logic             fv, fc, fsub, fsat;
  logic [SEG-1:0]   fa, fb, fbs, fsum;
  logic [SEG:0]     fcy;
  logic [WIDTH-1:0] raw, fres, sat_val;
  logic             fovf;

  if (STAGES == 1) begin : g_fin
    assign fv   = in_valid;
    assign fc   = sub;
    assign fsub = sub;
    assign fsat = sat;
    assign fa   = a;
    assign fb   = b;
    assign raw  = fsum;
  end else begin : g_fin
    assign fv   = g_st[LAST-1].v_q;
    assign fc   = g_st[LAST-1].c_q;
    assign fsub = g_st[LAST-1].sub_q;
    assign fsat = g_st[LAST-1].sat_q;
    assign fa   = g_st[LAST-1].a_q;
    assign fb   = g_st[LAST-1].b_q;
    assign raw  = {fsum, g_st[LAST-1].r_q};
  end

  assign fbs     = fsub ? ~fb : fb;
  assign fcy     = cla(fa & fbs, fa ^ fbs, fc);
  assign fsum    = fa ^ fbs ^ fcy[SEG-1:0];
  assign fovf    = fcy[SEG] ^ fcy[SEG-1];
  // fa[SEG-1] is the sign bit of operand A.
  assign sat_val = fa[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign fres    = (fsat && fovf) ? sat_val : raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      f         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else if (advance) begin
      out_valid <= fv;
      f         <= fres;
      cout      <= fcy[SEG];
      ovf       <= fovf;
      zero      <= (fres == '0);
      neg       <= fres[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub (WIDTH=16, SEG=4): directed vectors, latency, stall,
// random traffic with back-pressure, and mid-flight reset, checked by a scoreboard.
module tb_pipe_addsub;
  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         sat;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         neg;

  int checks = 0;
  int errors = 0;
  logic [W+3:0] exp_q[$];
  bit rnd_done;

  pipe_addsub #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference: sign-rule overflow, independent of any carry chain.
  function automatic logic [W+3:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic msub, input logic msat);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic [W-1:0] bx;
    logic         o;
    bx = msub ? ~mb : mb;
    s  = {1'b0, ma} + {1'b0, bx} + {{W{1'b0}}, msub};
    r  = s[W-1:0];
    if (msub) o = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
    else      o = (ma[W-1] == mb[W-1]) && (r[W-1] != ma[W-1]);
    if (msat && o) r = ma[W-1] ? 16'h8000 : 16'h7FFF;
    return {r, s[W], o, (r == 16'h0000), r[W-1]};
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                      input logic tsat, input logic [W+3:0] texp);
    int n;
    @(negedge clk);
    a = ta; b = tb; sub = tsub; sat = tsat; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready %b required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(texp);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [W+3:0] exp_v;
    #2;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra_beat got f=%h with nothing expected", f);
      end else begin
        exp_v = exp_q.pop_front();
        if ({f, cout, ovf, zero, neg} !== exp_v)
          begin
            errors++;
            $display("FAIL sb_result got f=%h c=%b o=%b z=%b n=%b required f=%h c=%b o=%b z=%b n=%b",
                     f, cout, ovf, zero, neg, exp_v[W+3:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
          end
      end
    end
  end

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s pending %0d required 0", tag, exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; sat = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
    checks++; if (f !== 16'h0000) begin errors++; $display("FAIL rst_f got %h required 0000", f); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL rst_zero got %b required 0", zero); end
    checks++; if ({cout, ovf, neg} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b required 000", {cout, ovf, neg}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b required 1", in_ready); end
  endtask

  task automatic test_directed();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0, 1'b1});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0});
    send(16'h0003, 16'h0005, 1'b1, 1'b0, {16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1});
    send(16'h8000, 16'h0001, 1'b1, 1'b1, {16'h8000, 1'b1, 1'b1, 1'b0, 1'b1});
    send(16'h0FFF, 16'h0001, 1'b0, 1'b0, {16'h1000, 1'b0, 1'b0, 1'b0, 1'b0});
    send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, {16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1});
    send(16'h8000, 16'h8000, 1'b0, 1'b1, {16'h8000, 1'b1, 1'b1, 1'b0, 1'b1});
    send(16'h0005, 16'h0005, 1'b1, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
    send(16'h7FFF, 16'hFFFF, 1'b1, 1'b1, {16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0});
    drain("directed");
  endtask

  task automatic test_latency();
    int lat;
    send(16'h1234, 16'h1111, 1'b0, 1'b0, model(16'h1234, 16'h1111, 1'b0, 1'b0));
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL latency got %0d required 4", lat); end
    drain("latency");
  endtask

  task automatic test_stall();
    logic [W+3:0] held;
    logic [W-1:0] va;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          va = 16'h1000 * (i + 1) + 16'h0ABC;
          send(va, 16'h0F0F, i[0], 1'b0, model(va, 16'h0F0F, i[0], 1'b0));
        end
      end
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b0;
        #2 held = {f, cout, ovf, zero, neg};
        for (int i = 0; i < 3; i++) begin
          if (i > 0) begin @(negedge clk); #2; end
          checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc %0d got %b required 0", i, in_ready); end
          checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid cyc %0d got %b required 1", i, out_valid); end
          checks++; if ({f, cout, ovf, zero, neg} !== held) begin errors++; $display("FAIL stall_hold cyc %0d got %h required %h", i, {f, cout, ovf, zero, neg}, held); end
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain("stall");
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic rs, rt;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          case ($urandom_range(0, 4))
            0: ra = 16'h7FFF;
            1: ra = 16'h8000;
            2: ra = 16'hFFFF;
            default: ra = 16'($urandom_range(0, 65535));
          endcase
          rb = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom_range(0, 65535));
          rs = 1'($urandom_range(0, 1));
          rt = 1'($urandom_range(0, 1));
          repeat ($urandom_range(0, 1)) @(negedge clk);
          send(ra, rb, rs, rt, model(ra, rb, rs, rt));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain("random");
  endtask

  task automatic test_reset_midflight();
    logic [W-1:0] va;
    bit seen;
    for (int i = 0; i < 4; i++) begin
      va = 16'h1111 * (i + 1);
      send(va, 16'h0101, 1'b0, 1'b0, model(va, 16'h0101, 1'b0, 1'b0));
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got %b required 1", out_valid); end
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b required 0", out_valid); end
    checks++; if ({f, cout, ovf, zero, neg} !== 20'h0) begin errors++; $display("FAIL midrst_outputs got %h required 00000", {f, cout, ovf, zero, neg}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #3;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midrst_stale_beat got out_valid 1 required 0"); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_latency();
    test_stall();
    test_random();
    test_reset_midflight();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
